// File: rtl/filter_sequencer.sv
// filter_sequencer: steps one audio sample through a selected FIR core
// over AXI-stream and rescales the 32-bit result to saturated 16 bits.
module filter_sequencer #(
    parameter int OUT_SHIFT      = 15,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int DROP_CNT_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            filter_sel,
    input  logic                  sample_valid,
    input  logic [15:0]           sample_in,
    output logic [15:0]           fir_s_tdata,
    output logic [2:0]            fir_s_tvalid,
    input  logic [2:0]            fir_s_tready,
    input  logic [95:0]           fir_m_tdata,
    input  logic [2:0]            fir_m_tvalid,
    output logic [2:0]            fir_m_tready,
    output logic [15:0]           audio_out,
    output logic                  done,
    output logic                  busy,
    output logic                  timeout,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] SEL_BYP = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [1:0]        sel_q;
    logic [2:0]        sel_oh;
    logic [31:0]       res_sel;
    logic signed [31:0] res_shift;
    logic [15:0]       res_sat;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic              s_hs;
    logic              m_hs;
    logic              accept;
    logic              drop;
    logic              abort;

    // one-hot view of the latched filter selection; bypass selects none
    always_comb begin
        sel_oh = 3'b000;
        unique case (sel_q)
            2'b00:   sel_oh = 3'b001;
            2'b01:   sel_oh = 3'b010;
            2'b10:   sel_oh = 3'b100;
            default: sel_oh = 3'b000;
        endcase
    end

    // pick the result lane belonging to the latched filter
    always_comb begin
        res_sel = fir_m_tdata[31:0];
        unique case (sel_q)
            2'b01:   res_sel = fir_m_tdata[63:32];
            2'b10:   res_sel = fir_m_tdata[95:64];
            default: res_sel = fir_m_tdata[31:0];
        endcase
    end

    // arithmetic rescale then clamp into the signed 16-bit range
    always_comb begin
        res_shift = $signed(res_sel) >>> OUT_SHIFT;
        res_sat   = res_shift[15:0];
        if (res_shift > 32'sd32767) begin
            res_sat = 16'h7FFF;
        end else if (res_shift < -32'sd32768) begin
            res_sat = 16'h8000;
        end
    end

    assign cnt_last = (cnt == CNT_LAST);
    assign s_hs     = |(fir_s_tready & sel_oh);
    assign m_hs     = |(fir_m_tvalid & sel_oh);
    assign accept   = (state == IDLE) && sample_valid;
    assign drop     = (state != IDLE) && sample_valid;
    assign abort    = ((state == SEND) && !s_hs && cnt_last) ||
                      ((state == WAIT) && !m_hs && cnt_last);

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state: handshake progress has priority over timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_nx = (filter_sel == SEL_BYP) ? OUT : SEND;
                end
            end
            SEND: begin
                if (s_hs) begin
                    state_nx = WAIT;
                end else if (cnt_last) begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (m_hs) begin
                    state_nx = OUT;
                end else if (cnt_last) begin
                    state_nx = IDLE;
                end
            end
            OUT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        fir_s_tvalid = 3'b000;
        fir_m_tready = 3'b000;
        done         = 1'b0;
        busy         = (state != IDLE);
        unique case (1'b1)
            state == SEND: fir_s_tvalid = sel_oh;
            state == WAIT: fir_m_tready = sel_oh;
            state == OUT:  done         = 1'b1;
            default: ;
        endcase
    end

    // sample and selection are frozen at accept for the whole transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fir_s_tdata <= '0;
            sel_q       <= 2'b00;
        end else if (accept) begin
            fir_s_tdata <= sample_in;
            sel_q       <= filter_sel;
        end
    end

    // handshake watchdog, restarted on every state change
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state != state_nx) begin
            cnt <= '0;
        end else if ((state == SEND) || (state == WAIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // result register: bypass loads the raw sample, filters the clamp
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            audio_out <= '0;
        end else if (accept && (filter_sel == SEL_BYP)) begin
            audio_out <= sample_in;
        end else if ((state == WAIT) && m_hs) begin
            audio_out <= res_sat;
        end
    end

    // single-cycle abort flag, lands in the first IDLE cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= abort;
        end
    end

    // saturating count of strobes that arrive while busy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// tb_filter_sequencer: directed bench for filter_sequencer,
// main instance plus a short-watchdog instance sharing the inputs.
module tb_filter_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  filter_sel;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic [2:0]  fir_s_tready;
    logic [95:0] fir_m_tdata;
    logic [2:0]  fir_m_tvalid;

    logic [15:0] s_tdata_a, s_tdata_b;
    logic [2:0]  s_tvalid_a, s_tvalid_b;
    logic [2:0]  m_tready_a, m_tready_b;
    logic [15:0] audio_a, audio_b;
    logic        done_a, done_b;
    logic        busy_a, busy_b;
    logic        tout_a, tout_b;
    logic [7:0]  drop_a, drop_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    filter_sequencer #(
        .OUT_SHIFT(15), .TIMEOUT_CYCLES(64), .DROP_CNT_W(8)
    ) u_dut (
        .clock(clock), .reset_n(reset_n),
        .filter_sel(filter_sel), .sample_valid(sample_valid),
        .sample_in(sample_in),
        .fir_s_tdata(s_tdata_a), .fir_s_tvalid(s_tvalid_a),
        .fir_s_tready(fir_s_tready),
        .fir_m_tdata(fir_m_tdata), .fir_m_tvalid(fir_m_tvalid),
        .fir_m_tready(m_tready_a),
        .audio_out(audio_a), .done(done_a), .busy(busy_a),
        .timeout(tout_a), .drop_count(drop_a)
    );

    filter_sequencer #(
        .OUT_SHIFT(15), .TIMEOUT_CYCLES(16), .DROP_CNT_W(8)
    ) u_dut16 (
        .clock(clock), .reset_n(reset_n),
        .filter_sel(filter_sel), .sample_valid(sample_valid),
        .sample_in(sample_in),
        .fir_s_tdata(s_tdata_b), .fir_s_tvalid(s_tvalid_b),
        .fir_s_tready(fir_s_tready),
        .fir_m_tdata(fir_m_tdata), .fir_m_tvalid(fir_m_tvalid),
        .fir_m_tready(m_tready_b),
        .audio_out(audio_b), .done(done_b), .busy(busy_b),
        .timeout(tout_b), .drop_count(drop_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // one filter transfer: ready at once, result one cycle into WAIT
    task automatic run_filt(input logic [1:0] sel, input logic [15:0] smp,
                            input logic [31:0] res, input logic [15:0] exp);
        logic [2:0] oh;
        oh           = 3'b001 << sel;
        fir_s_tready = oh;
        fir_m_tvalid = 3'b000;
        filter_sel   = sel;
        sample_in    = smp;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("run_svalid", {29'd0, s_tvalid_a}, {29'd0, oh});
        check("run_sdata", {16'd0, s_tdata_a}, {16'd0, smp});
        step();
        check("run_mready", {29'd0, m_tready_a}, {29'd0, oh});
        fir_m_tdata = {3{32'hDEADBEEF}};
        fir_m_tdata[sel*32 +: 32] = res;
        fir_m_tvalid = oh;
        step();
        check("run_done", {31'd0, done_a}, 32'd1);
        check("run_audio", {16'd0, audio_a}, {16'd0, exp});
        fir_m_tvalid = 3'b000;
        fir_s_tready = 3'b000;
        step();
        check("run_idle", {31'd0, busy_a}, 32'd0);
        check("run_done_end", {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        filter_sel   = 2'b00;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        fir_s_tready = 3'b000;
        fir_m_tdata  = '0;
        fir_m_tvalid = 3'b000;
        step();
        step();

        check("rst_audio", {16'd0, audio_a}, 32'd0);
        check("rst_sdata", {16'd0, s_tdata_a}, 32'd0);
        check("rst_sv_mr", {26'd0, s_tvalid_a, m_tready_a}, 32'd0);
        check("rst_flags", {29'd0, done_a, busy_a, tout_a}, 32'd0);
        check("rst_drop", {24'd0, drop_a}, 32'd0);
        check("rst_b_all", {s_tdata_b, s_tvalid_b, m_tready_b,
                            done_b, busy_b, tout_b, 7'd0}, 32'd0);
        check("rst_b_out", {8'd0, audio_b, drop_b}, 32'd0);
        reset_n = 1'b1;
        step();

        // HPF: ready at once, result after 5 WAIT cycles
        fir_s_tready = 3'b111;
        filter_sel   = 2'b00;
        sample_in    = 16'h1234;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("hpf_svalid", {29'd0, s_tvalid_a}, 32'h1);
        check("hpf_sdata", {16'd0, s_tdata_a}, 32'h1234);
        check("hpf_busy", {31'd0, busy_a}, 32'd1);
        fir_m_tvalid = 3'b110;
        fir_m_tdata  = {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h12340000};
        step();
        check("hpf_svalid_off", {29'd0, s_tvalid_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("hpf_mready", {29'd0, m_tready_a}, 32'h1);
            check("hpf_nodone", {31'd0, done_a}, 32'd0);
            step();
        end
        fir_m_tvalid = 3'b111;
        step();
        check("hpf_done", {31'd0, done_a}, 32'd1);
        check("hpf_audio", {16'd0, audio_a}, 32'h2468);
        check("hpf_mready_off", {29'd0, m_tready_a}, 32'd0);
        fir_m_tvalid = 3'b000;
        fir_s_tready = 3'b000;
        step();
        check("hpf_done_pulse", {31'd0, done_a}, 32'd0);
        check("hpf_hold", {16'd0, audio_a}, 32'h2468);

        // saturation and in-range negative
        run_filt(2'b10, 16'h0100, 32'h7FFFFFFF, 16'h7FFF);
        run_filt(2'b10, 16'h0101, 32'h80000000, 16'h8000);
        run_filt(2'b01, 16'h0102, 32'hFFFF0000, 16'hFFFE);

        // bypass: done in the cycle after accept
        filter_sel   = 2'b11;
        sample_in    = 16'hBEEF;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("byp_done", {31'd0, done_a}, 32'd1);
        check("byp_audio", {16'd0, audio_a}, 32'hBEEF);
        check("byp_svalid", {29'd0, s_tvalid_a}, 32'd0);
        step();
        check("byp_end", {30'd0, done_a, busy_a}, 32'd0);

        // BPF back-pressure with selection toggling underneath
        filter_sel   = 2'b01;
        sample_in    = 16'h0ABC;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            filter_sel = 2'(i);
            check("bp_svalid", {29'd0, s_tvalid_a}, 32'h2);
            check("bp_sdata", {16'd0, s_tdata_a}, 32'h0ABC);
            step();
        end
        fir_s_tready = 3'b010;
        check("bp_svalid_rdy", {29'd0, s_tvalid_a}, 32'h2);
        step();
        fir_s_tready = 3'b000;
        check("bp_svalid_off", {29'd0, s_tvalid_a}, 32'd0);
        check("bp_mready", {29'd0, m_tready_a}, 32'h2);
        fir_m_tdata  = {32'hDEADBEEF, 32'h00010000, 32'hDEADBEEF};
        fir_m_tvalid = 3'b010;
        step();
        check("bp_audio", {16'd0, audio_a}, 32'h0002);
        fir_m_tvalid = 3'b000;
        step();
        run_filt(2'b00, 16'h0002, 32'h00038000, 16'h0007);

        // overrun: back-to-back bypass, every OUT cycle drops a strobe
        filter_sel   = 2'b11;
        sample_in    = 16'h0F0F;
        sample_valid = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (i == 20) check("ovr_drop20", {24'd0, drop_a}, 32'd10);
            if (i == 21) check("ovr_done21", {31'd0, done_a}, 32'd1);
            if (i == 508) check("ovr_drop508", {24'd0, drop_a}, 32'd254);
        end
        sample_valid = 1'b0;
        check("ovr_sat", {24'd0, drop_a}, 32'd255);
        check("ovr_audio", {16'd0, audio_a}, 32'h0F0F);
        step();

        // fresh start, then give both a known audio_out
        reset_n = 1'b0;
        step();
        check("rst2_drop", {24'd0, drop_a}, 32'd0);
        reset_n = 1'b1;
        step();
        run_filt(2'b10, 16'h0011, 32'h00008000, 16'h0001);
        check("to_pre_audio", {16'd0, audio_b}, 32'h0001);

        // timeout on the 16-cycle instance: HPF never answers
        fir_s_tready = 3'b001;
        filter_sel   = 2'b00;
        sample_in    = 16'h5555;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("to_svalid", {29'd0, s_tvalid_b}, 32'h1);
        step();
        for (int i = 0; i < 16; i++) begin
            check("to_mready", {29'd0, m_tready_b}, 32'h1);
            check("to_quiet", {30'd0, tout_b, done_b}, 32'd0);
            step();
        end
        check("to_pulse", {31'd0, tout_b}, 32'd1);
        check("to_mready_off", {29'd0, m_tready_b}, 32'd0);
        check("to_idle", {30'd0, busy_b, done_b}, 32'd0);
        check("to_audio", {16'd0, audio_b}, 32'h0001);
        step();
        check("to_pulse_end", {30'd0, tout_b, done_b}, 32'd0);

        // async reset while the main instance still sits in WAIT
        check("wr_in_wait", {29'd0, m_tready_a}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("wr_mready", {29'd0, m_tready_a}, 32'd0);
        check("wr_flags", {28'd0, s_tvalid_a, busy_a}, 32'd0);
        check("wr_audio", {16'd0, audio_a}, 32'd0);
        check("wr_sdata", {16'd0, s_tdata_a}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        run_filt(2'b01, 16'h4000, 32'h20000000, 16'h4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
- Sequences one audio sample at a time through one of three shared-input FIR filter cores: high-pass, band-pass or low-pass. All three have AXI-stream slave and master ports.
- Latches the filter selection per sample, performs the slave/master handshakes, and rescales the 32-bit filter result to 16 bits with saturation.
- Sits between the audio sample source (ADC/deserializer strobe) and the audio output path; provides bypass, timeout and overrun reporting.

Parameters:
- OUT_SHIFT, 15, right-shift applied to the 32-bit filter result before 16-bit saturation (legal range 0..16)
- TIMEOUT_CYCLES, 1023, max cycles waited in any handshake state before abort (min 2)
- DROP_CNT_W, 8, width of saturating dropped-sample counter

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- filter_sel  in  2  00=HPF, 01=BPF, 10=LPF, 11=bypass; sampled only at sample acceptance
- sample_valid  in  1  one-cycle strobe, new sample on sample_in
- sample_in  in  16  signed audio sample
- fir_s_tdata  out  16  shared slave data bus to all three filters
- fir_s_tvalid  out  3  per-filter slave valid, bit0=HPF, bit1=BPF, bit2=LPF
- fir_s_tready  in  3  per-filter slave ready
- fir_m_tdata  in  96  per-filter 32-bit result, [31:0]=HPF, [63:32]=BPF, [95:64]=LPF
- fir_m_tvalid  in  3  per-filter master valid
- fir_m_tready  out  3  per-filter master ready
- audio_out  out  16  signed filtered sample, held until next done
- done  out  1  one-cycle pulse, audio_out updated this cycle
- busy  out  1  high in any state other than IDLE
- timeout  out  1  one-cycle pulse on handshake abort
- drop_count  out  DROP_CNT_W  saturating count of samples refused while busy

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including fir_s_tvalid, fir_m_tready, audio_out and drop_count; latched selection=00; fir_s_tdata=0.
- States: IDLE, SEND, WAIT, OUT.
- IDLE, sample_valid=1:
  - Latch sample_in into fir_s_tdata and filter_sel into sel_q.
  - sel_q=11: go to OUT with the raw sample as result.
  - Otherwise: go to SEND and clear the timeout counter.
- SEND:
  - fir_s_tvalid = one-hot(sel_q); fir_s_tdata stable.
  - On fir_s_tready[sel_q]=1 in the same cycle: transfer complete, go to WAIT, clear the counter.
  - Only the selected filter's bit may be 1; the other two are 0.
- WAIT:
  - fir_m_tready = one-hot(sel_q).
  - On fir_m_tvalid[sel_q]=1: capture fir_m_tdata slice of sel_q, go to OUT.
  - Non-selected m_tvalid bits are ignored; their m_tready stays 0.
- OUT: audio_out updated, done=1 for exactly one cycle, return to IDLE.
  - Accept-to-done latency for a filter is 2 cycles + s_tready wait + filter latency + 1.
  - Accept-to-done latency for bypass is exactly 2 cycles: done is high in the cycle after the accept edge.
- Scaling, shifted value v = result >>> OUT_SHIFT (arithmetic):
  - v > 32767 gives 0x7FFF.
  - v < -32768 gives 0x8000.
  - Otherwise audio_out = v[15:0].
- Timeout:
  - Counter increments each cycle in SEND or WAIT.
  - Reaching TIMEOUT_CYCLES: deassert all tvalid/tready, timeout=1 for one cycle, return to IDLE.
  - audio_out is unchanged and no done pulse is issued.
- Overrun:
  - sample_valid while busy=1, including in OUT, means the sample is dropped.
  - drop_count increments and saturates at all-ones.
  - sample_valid in IDLE is always accepted.
- filter_sel changes while busy have no effect until the next accept.
- Reset mid-transfer: immediate return to IDLE with all handshake outputs 0; a partially handshaken sample is discarded.
- No combinational path from any input to any output.

Test Plan:
- HPF path:
  - Stimulus: filter_sel=00, sample 0x1234; model tready=1 immediately, returns m_tdata=0x12340000 after 5 cycles; OUT_SHIFT=15.
  - Response: fir_s_tvalid=001 for 1 cycle; audio_out=0x2468; done is a single pulse; fir_m_tready only on bit0.
- Saturation:
  - Stimulus: LPF returns 0x7FFFFFFF.
  - Response: audio_out=0x7FFF.
  - Stimulus: LPF returns 0x80000000.
  - Response: audio_out=0x8000.
- Bypass:
  - Stimulus: filter_sel=11, sample 0xBEEF.
  - Response: done exactly 2 cycles after accept, audio_out=0xBEEF, fir_s_tvalid never asserted.
- Back-pressure and selection hold:
  - Stimulus: BPF holds s_tready=0 for 20 cycles; filter_sel toggled meanwhile.
  - Response: fir_s_tvalid=010 held steady with constant data; the transfer completes on the ready cycle; the next sample uses the new selection.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, HPF never asserts m_tvalid.
  - Response: timeout pulse 16 cycles into WAIT; tready drops; audio_out retains the prior value; no done pulse.
- Overrun and reset:
  - Stimulus: 300 sample_valid strobes while busy.
  - Response: drop_count=255 (saturated).
  - Stimulus: reset_n asserted in WAIT.
  - Response: all outputs 0 asynchronously; after release, a fresh sample is accepted normally.
